// File: rtl/ram1_sample_buffer.sv
// Whitened-sample store (MEM1) feeding the FastICA core: one write pass,
// then any number of non-destructive read passes from a programmable base offset.
module ram1_sample_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              go,
  input  logic              go_ram1,
  input  logic              rw,
  input  logic              new_one,
  input  logic [13:0]       address_sel_mem1,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p1;
  logic              last_p1;
  logic [DATA_W-1:0] data_p1;

  logic              wr_fire;
  logic              rd_fire;
  logic              rd_end;
  logic [ADDR_W-1:0] rd_addr;

  // Offset reads wrap naturally in ADDR_W bits, i.e. modulo DEPTH.
  function automatic logic [ADDR_W-1:0] rd_addr_f(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] idx);
    return base + idx;
  endfunction

  generate
    if (ADDR_W < 14) begin : g_sel_unused
      logic unused_sel;
      assign unused_sel = ^address_sel_mem1[13:ADDR_W];
    end
  endgenerate

  assign full     = (cnt == DEPTH_CNT);
  assign empty    = (cnt == '0);
  assign wr_ready = (state == WRITE) && !full;
  assign wr_fire  = wr_ready && wr_valid;
  assign rd_fire  = (state == READ) && rd_req && (rd_idx < cnt);
  assign rd_end   = rd_fire && ((rd_idx + (ADDR_W+1)'(1)) == cnt);
  assign rd_addr  = rd_addr_f(address_sel_mem1[ADDR_W-1:0], rd_idx[ADDR_W-1:0]);

  // Stage p0 -> p1: control, pointers and registered read data
  always_ff @(posedge clk or negedge go) begin
    if (!go) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_idx  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (new_one) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_idx  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= rd_fire;
      last_p1 <= rd_end;
      if (rd_fire) begin
        data_p1 <= mem[rd_addr];
        rd_idx  <= rd_idx + (ADDR_W+1)'(1);
      end
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        cnt    <= cnt + (ADDR_W+1)'(1);
      end
      if ((state == WRITE) && wr_valid && full) ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (go_ram1) begin
            if (rw) begin
              state <= WRITE;
            end else if (!empty) begin
              state  <= READ;
              rd_idx <= '0;
            end
          end
        end
        WRITE: begin
          if (!go_ram1) begin
            state <= IDLE;
          end else if (!rw) begin
            if (!empty) begin
              state  <= READ;
              rd_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          if (!go_ram1)    state <= IDLE;
          else if (rd_end) state <= DONE;
        end
        default: begin
          if (!go_ram1) state <= IDLE;
        end
      endcase
    end
  end

  // Sample memory carries no reset; only the write port touches it.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = vld_p1;
  assign rd_last  = last_p1;
  assign rd_data  = data_p1;
  assign count    = cnt;
  assign overflow = ovf;
  assign busy     = (state == WRITE) || (state == READ);

endmodule

// File: tb/tb_ram1_sample_buffer.sv
// Directed bench for ram1_sample_buffer with a 16-entry buffer (ADDR_W=4).
module tb_ram1_sample_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              go = 1'b0;
  logic              go_ram1 = 1'b0;
  logic              rw = 1'b0;
  logic              new_one = 1'b0;
  logic [13:0]       address_sel_mem1 = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_req = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  ram1_sample_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .go(go), .go_ram1(go_ram1), .rw(rw), .new_one(new_one),
    .address_sel_mem1(address_sel_mem1), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic clear_set();
    new_one = 1'b1;
    step();
    new_one = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    step();
    go = 1'b1;
    step();

    // 1: five samples, then one read pass
    go_ram1 = 1'b1; rw = 1'b1;
    step();
    chk("t1_busy_write", 32'(busy), 32'd1);
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 5; i++) write_sample(16'h0011 + 16'(i));
    chk("t1_count", 32'(count), 32'd5);
    rw = 1'b0;
    step();
    chk("t1_wr_ready_read", 32'(wr_ready), 32'd0);
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_rd_valid", 32'(rd_valid), 32'd1);
      chk("t1_rd_data", 32'(rd_data), 32'h0011 + 32'(i));
      chk("t1_rd_last", 32'(rd_last), (i == 4) ? 32'd1 : 32'd0);
    end
    rd_req = 1'b0;
    step();
    chk("t1_done_no_valid", 32'(rd_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // 4: replay gives the identical sequence
    go_ram1 = 1'b0;
    step();
    go_ram1 = 1'b1;
    step();
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_rd_data", 32'(rd_data), 32'h0011 + 32'(i));
      chk("t4_rd_last", 32'(rd_last), (i == 4) ? 32'd1 : 32'd0);
    end
    rd_req = 1'b0;
    chk("t4_count", 32'(count), 32'd5);
    go_ram1 = 1'b0;
    step();

    // 2: fill to DEPTH, then two more offered samples
    clear_set();
    chk("t2_cleared", 32'(count), 32'd0);
    go_ram1 = 1'b1; rw = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) write_sample(16'h0100 + 16'(i));
    write_sample(16'hDEAD);
    write_sample(16'hBEEF);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    chk("t2_count", 32'(count), 32'(DEPTH));
    chk("t2_overflow", 32'(overflow), 32'd1);
    rw = 1'b0;
    step();
    rd_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t2_rd_data", 32'(rd_data), 32'h0100 + 32'(i));
      chk("t2_rd_last", 32'(rd_last), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    rd_req = 1'b0;
    go_ram1 = 1'b0;
    step();
    chk("t2_overflow_sticky", 32'(overflow), 32'd1);

    // 3: base offset DEPTH-2 (upper select bits set) wraps around
    address_sel_mem1 = 14'h3FFE;
    go_ram1 = 1'b1;
    step();
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_rd_valid", 32'(rd_valid), 32'd1);
      chk("t3_rd_data", 32'(rd_data), 32'h0100 + 32'((14 + i) % DEPTH));
    end

    // 5: asynchronous reset mid-READ
    go = 1'b0;
    #1;
    chk("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_rst_rd_data", 32'(rd_data), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_overflow", 32'(overflow), 32'd0);
    rd_req = 1'b0; go_ram1 = 1'b0; address_sel_mem1 = '0;
    #2;
    go = 1'b1;
    step();

    // 5b: new_one mid-WRITE restarts at address 0
    go_ram1 = 1'b1; rw = 1'b1;
    step();
    for (int i = 0; i < 3; i++) write_sample(16'h0031 + 16'(i));
    clear_set();
    chk("t5_new_one_count", 32'(count), 32'd0);
    step();
    write_sample(16'h0077);
    chk("t5_count_one", 32'(count), 32'd1);
    rw = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("t5_rd_data", 32'(rd_data), 32'h0077);
    chk("t5_rd_last", 32'(rd_last), 32'd1);
    go_ram1 = 1'b0;
    step();

    // 6: read request on an empty buffer stays IDLE
    clear_set();
    go_ram1 = 1'b1; rw = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    end
    rd_req = 1'b0; go_ram1 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
